// File: rtl/data_mover_mc_pkg.sv
// Shared types for the multi-channel data mover: metadata and flit layouts,
// packet flag encodings, buffer address width and FSM state encoding.
package data_mover_mc_pkg;

   localparam int PKTBUF_AWIDTH  = 10;
   localparam int FLIT_IDX_W_DEF = 5;
   localparam int PKTID_W_DEF    = PKTBUF_AWIDTH - FLIT_IDX_W_DEF;
   localparam int FLITS_W        = 8;
   localparam int NUM_FLAGS      = 5;

   localparam logic [2:0] PKT_FORWARD     = 3'd0;
   localparam logic [2:0] PKT_DROP        = 3'd1;
   localparam logic [2:0] PKT_CHECK       = 3'd2;
   localparam logic [2:0] PKT_OOO         = 3'd3;
   localparam logic [2:0] PKT_FORWARD_OOO = 3'd4;

   typedef struct packed {
      logic [PKTID_W_DEF-1:0] pkt_id;
      logic [FLITS_W-1:0]     flits;
      logic [2:0]             pkt_flags;
   } metadata_t;

   typedef struct packed {
      logic [511:0] data;
      logic [5:0]   empty;
   } flit_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FREE  = 2'd3
   } state_t;

endpackage

// File: rtl/data_mover_mc_stats_sat_cnt.sv
// Saturating statistics counter: counts inc pulses, sticks at all-ones.
module stats_sat_cnt #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count register; holds once every bit is set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= {W{1'b0}};
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/data_mover_mc.sv
// Moves packets from a shared packet buffer to one of NUM_CH output channels,
// then returns the buffer slot to the emptylist. Keeps saturating statistics.
module data_mover_mc
   import data_mover_mc_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int STATS_W    = 32,
   parameter int FLIT_IDX_W = 5,
   parameter int PKTID_W    = PKTBUF_AWIDTH - FLIT_IDX_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         meta_valid,
   output logic                         meta_ready,
   input  metadata_t                    meta_data,
   input  logic [$clog2(NUM_CH)-1:0]    meta_chan,
   output logic [PKTBUF_AWIDTH-1:0]     pkt_buffer_address,
   output logic                         pkt_buffer_read,
   input  logic                         pkt_buffer_readvalid,
   input  flit_t                        pkt_buffer_readdata,
   output logic [NUM_CH-1:0]            out_valid,
   output logic [NUM_CH-1:0]            out_sop,
   output logic [NUM_CH-1:0]            out_eop,
   output logic [511:0]                 out_data,
   output logic [5:0]                   out_empty,
   input  logic [NUM_CH-1:0]            out_almost_full,
   output logic                         emptylist_valid,
   output logic [PKTID_W-1:0]           emptylist_data,
   input  logic                         emptylist_ready,
   output logic [NUM_FLAGS*STATS_W-1:0] stats_flag,
   output logic [NUM_CH*STATS_W-1:0]    stats_chan_pkt,
   output logic [STATS_W-1:0]           stats_nopayload
);

   localparam int CH_W      = $clog2(NUM_CH);
   localparam int CNT_W     = FLIT_IDX_W + 1;
   localparam int MAX_FLITS = 2 ** FLIT_IDX_W;

   state_t             state_r;
   state_t             state_nxt;
   logic [PKTID_W-1:0] pkt_id_r;
   logic [CNT_W-1:0]   flits_r;
   logic [CH_W-1:0]    chan_r;
   logic [CNT_W-1:0]   rd_idx_r;
   logic [CNT_W-1:0]   ret_cnt_r;
   logic               rv_r;
   flit_t              rd_flit_r;

   logic               meta_fire_s;
   logic               meta_skip_s;
   logic               meta_nopay_s;
   logic [CNT_W-1:0]   meta_flits_s;
   logic               read_s;
   logic               last_read_s;
   logic               is_sop_s;
   logic               is_eop_s;

   assign meta_ready   = (state_r == ST_IDLE) && !rst;
   assign meta_fire_s  = meta_valid && meta_ready;
   assign meta_nopay_s = (meta_data.flits == {FLITS_W{1'b0}});
   assign meta_skip_s  = meta_nopay_s || (meta_data.pkt_flags == PKT_DROP);
   assign read_s       = (state_r == ST_READ) && !out_almost_full[chan_r];
   assign last_read_s  = read_s && (rd_idx_r == (flits_r - CNT_W'(1)));
   assign is_sop_s     = rv_r && (ret_cnt_r == {CNT_W{1'b0}});
   assign is_eop_s     = rv_r && (ret_cnt_r == (flits_r - CNT_W'(1)));

   // Oversized flit counts are clamped to what the index field can address.
   always_comb begin
      meta_flits_s = meta_data.flits[CNT_W-1:0];
      if (meta_data.flits > FLITS_W'(MAX_FLITS)) begin
         meta_flits_s = CNT_W'(MAX_FLITS);
      end else begin
         meta_flits_s = meta_data.flits[CNT_W-1:0];
      end
   end

   // Next-state logic for the packet FSM.
   always_comb begin
      state_nxt = state_r;
      case (state_r)
         ST_IDLE: begin
            if (meta_fire_s) begin
               state_nxt = meta_skip_s ? ST_FREE : ST_READ;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_READ: begin
            if (last_read_s) state_nxt = ST_DRAIN;
            else             state_nxt = ST_READ;
         end
         ST_DRAIN: begin
            if (ret_cnt_r == flits_r) state_nxt = ST_FREE;
            else                      state_nxt = ST_DRAIN;
         end
         ST_FREE: begin
            if (emptylist_ready) state_nxt = ST_IDLE;
            else                 state_nxt = ST_FREE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // FSM state and per-packet context registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         pkt_id_r  <= {PKTID_W{1'b0}};
         flits_r   <= {CNT_W{1'b0}};
         chan_r    <= {CH_W{1'b0}};
         rd_idx_r  <= {CNT_W{1'b0}};
         ret_cnt_r <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt;
         if (meta_fire_s) begin
            pkt_id_r  <= meta_data.pkt_id;
            flits_r   <= meta_flits_s;
            chan_r    <= meta_chan;
            rd_idx_r  <= {CNT_W{1'b0}};
            ret_cnt_r <= {CNT_W{1'b0}};
         end else begin
            if (read_s) rd_idx_r  <= rd_idx_r + CNT_W'(1);
            if (rv_r)   ret_cnt_r <= ret_cnt_r + CNT_W'(1);
         end
      end
   end

   // Return-path stage; stray returns outside a packet are dropped here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rv_r      <= 1'b0;
         rd_flit_r <= '0;
      end else begin
         rv_r <= pkt_buffer_readvalid &&
                 ((state_r == ST_READ) || (state_r == ST_DRAIN));
         if (pkt_buffer_readvalid) rd_flit_r <= pkt_buffer_readdata;
      end
   end

   assign pkt_buffer_read    = read_s;
   assign pkt_buffer_address = {pkt_id_r, rd_idx_r[FLIT_IDX_W-1:0]};
   assign emptylist_valid    = (state_r == ST_FREE);
   assign emptylist_data     = pkt_id_r;
   assign out_data           = rd_flit_r.data;

   // Channel qualifiers are decoded from the registered return stage.
   always_comb begin
      out_valid = {NUM_CH{1'b0}};
      out_sop   = {NUM_CH{1'b0}};
      out_eop   = {NUM_CH{1'b0}};
      out_empty = 6'd0;
      if (rv_r) begin
         out_valid = {{(NUM_CH-1){1'b0}}, 1'b1} << chan_r;
         out_sop   = {{(NUM_CH-1){1'b0}}, is_sop_s} << chan_r;
         out_eop   = {{(NUM_CH-1){1'b0}}, is_eop_s} << chan_r;
         out_empty = is_eop_s ? rd_flit_r.empty : 6'd0;
      end else begin
         out_valid = {NUM_CH{1'b0}};
      end
   end

   genvar k;
   generate
      for (k = 0; k < NUM_FLAGS; k++) begin : g_flag_cnt
         stats_sat_cnt #(.W(STATS_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (meta_fire_s && (meta_data.pkt_flags == 3'(k))),
            .count (stats_flag[k*STATS_W +: STATS_W])
         );
      end
      for (k = 0; k < NUM_CH; k++) begin : g_chan_cnt
         stats_sat_cnt #(.W(STATS_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (is_eop_s && (chan_r == CH_W'(k))),
            .count (stats_chan_pkt[k*STATS_W +: STATS_W])
         );
      end
   endgenerate

   stats_sat_cnt #(.W(STATS_W)) u_nopay_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (meta_fire_s && meta_nopay_s),
      .count (stats_nopayload)
   );

endmodule

// File: tb/tb_data_mover_mc.sv
// Randomized bench for data_mover_mc against a packet-level reference model.
module tb_data_mover_mc;
   import data_mover_mc_pkg::*;

   localparam int NC = 4;
   localparam int SW = 8;
   localparam int SMAX = 255;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic meta_valid = 1'b0;
   logic meta_ready;
   metadata_t meta_data = '0;
   logic [1:0] meta_chan = 2'd0;
   logic [9:0] pkt_buffer_address;
   logic pkt_buffer_read;
   logic pkt_buffer_readvalid = 1'b0;
   flit_t pkt_buffer_readdata = '0;
   logic [NC-1:0] out_valid, out_sop, out_eop;
   logic [511:0] out_data;
   logic [5:0] out_empty;
   logic [NC-1:0] out_almost_full = 4'd0;
   logic emptylist_valid;
   logic [4:0] emptylist_data;
   logic emptylist_ready = 1'b1;
   logic [5*SW-1:0] stats_flag;
   logic [NC*SW-1:0] stats_chan_pkt;
   logic [SW-1:0] stats_nopayload;

   data_mover_mc #(.NUM_CH(NC), .STATS_W(SW), .FLIT_IDX_W(5)) dut (
      .clk(clk), .rst(rst),
      .meta_valid(meta_valid), .meta_ready(meta_ready),
      .meta_data(meta_data), .meta_chan(meta_chan),
      .pkt_buffer_address(pkt_buffer_address), .pkt_buffer_read(pkt_buffer_read),
      .pkt_buffer_readvalid(pkt_buffer_readvalid), .pkt_buffer_readdata(pkt_buffer_readdata),
      .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
      .out_data(out_data), .out_empty(out_empty), .out_almost_full(out_almost_full),
      .emptylist_valid(emptylist_valid), .emptylist_data(emptylist_data),
      .emptylist_ready(emptylist_ready),
      .stats_flag(stats_flag), .stats_chan_pkt(stats_chan_pkt),
      .stats_nopayload(stats_nopayload)
   );

   always #5 clk = ~clk;

   typedef struct { int due; logic [9:0] a; } req_t;
   typedef struct { logic [3:0] af; logic [9:0] a; } rd_obs_t;
   typedef struct { logic [3:0] v; logic [3:0] sop; logic [3:0] eop; logic [511:0] d; logic [5:0] e; } fl_obs_t;

   req_t    rq[$];
   rd_obs_t obs_rd[$];
   fl_obs_t obs_fl[$];
   logic [4:0] obs_free[$];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_due = 0;
   int lat_min = 1;
   int lat_max = 4;
   int m_flag[5];
   int m_chan[NC];
   int m_nop;

   function automatic logic [511:0] mem_data(logic [9:0] a);
      logic [31:0] w;
      w = ({22'd0, a} * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
      return {16{w}};
   endfunction

   function automatic logic [5:0] mem_empty(logic [9:0] a);
      return a[5:0] ^ 6'h2B;
   endfunction

   function automatic int sat_inc(int x);
      return (x >= SMAX) ? SMAX : x + 1;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Buffer responder (in-order, random latency) and output recorder.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         rq.delete();
         pkt_buffer_readvalid = 1'b0;
         last_due = 0;
      end else begin
         if (pkt_buffer_read) begin
            req_t r;
            obs_rd.push_back('{af: out_almost_full, a: pkt_buffer_address});
            r.a = pkt_buffer_address;
            r.due = cyc + $urandom_range(lat_max, lat_min);
            if (r.due <= last_due) r.due = last_due + 1;
            last_due = r.due;
            rq.push_back(r);
         end
         if (out_valid != 4'd0)
            obs_fl.push_back('{v: out_valid, sop: out_sop, eop: out_eop, d: out_data, e: out_empty});
         if (emptylist_valid && emptylist_ready) obs_free.push_back(emptylist_data);
         if (rq.size() > 0 && rq[0].due <= cyc) begin
            pkt_buffer_readvalid = 1'b1;
            pkt_buffer_readdata.data = mem_data(rq[0].a);
            pkt_buffer_readdata.empty = mem_empty(rq[0].a);
            void'(rq.pop_front());
         end else begin
            pkt_buffer_readvalid = 1'b0;
            pkt_buffer_readdata = '0;
         end
      end
   end

   task automatic model_clear();
      for (int i = 0; i < 5; i++) m_flag[i] = 0;
      for (int i = 0; i < NC; i++) m_chan[i] = 0;
      m_nop = 0;
   endtask

   task automatic check_stats(input string tag);
      for (int i = 0; i < 5; i++) begin
         total++;
         if (stats_flag[i*SW +: SW] !== SW'(m_flag[i])) begin
            bad++;
            $display("FAIL %s stats_flag[%0d]: got %0d exp %0d", tag, i, stats_flag[i*SW +: SW], m_flag[i]);
         end
      end
      for (int i = 0; i < NC; i++) begin
         total++;
         if (stats_chan_pkt[i*SW +: SW] !== SW'(m_chan[i])) begin
            bad++;
            $display("FAIL %s stats_chan_pkt[%0d]: got %0d exp %0d", tag, i, stats_chan_pkt[i*SW +: SW], m_chan[i]);
         end
      end
      total++;
      if (stats_nopayload !== SW'(m_nop)) begin
         bad++;
         $display("FAIL %s stats_nopayload: got %0d exp %0d", tag, stats_nopayload, m_nop);
      end
   endtask

   // Present one meta and follow the packet until its emptylist push.
   task automatic send_pkt(input int id, input int flits, input int flags, input int ch,
                           input int af_start, input int af_len, input int er_hold,
                           input bit rand_af, output int done_rel);
      int n, rel, hold_cnt, w;
      bit done;
      logic [3:0] af, exp_v;
      logic [9:0] exp_a;
      w = 0;
      while (!meta_ready && w < 200) begin
         @(negedge clk); #1;
         w++;
      end
      total++;
      if (!meta_ready) begin
         bad++;
         $display("FAIL meta_ready_wait: got 0 exp 1 (pkt %0d)", id);
      end
      obs_rd.delete(); obs_fl.delete(); obs_free.delete();
      @(posedge clk); #1;
      meta_valid = 1'b1;
      meta_data.pkt_id = 5'(id);
      meta_data.flits = 8'(flits);
      meta_data.pkt_flags = 3'(flags);
      meta_chan = 2'(ch);
      emptylist_ready = (er_hold == 0);
      @(posedge clk); #1;
      meta_valid = 1'b0;
      rel = 0; hold_cnt = 0; done = 1'b0;
      while (!done && rel < 600) begin
         af = 4'd0;
         if (rand_af && $urandom_range(0, 3) == 0) af = 4'($urandom);
         if (rel >= af_start && rel < af_start + af_len) af[ch] = 1'b1;
         out_almost_full = af;
         emptylist_ready = (hold_cnt >= er_hold);
         @(negedge clk); #1;
         if (emptylist_valid && !emptylist_ready) begin
            hold_cnt++;
            total++;
            if (emptylist_data !== 5'(id) || meta_ready !== 1'b0) begin
               bad++;
               $display("FAIL free_hold: got data %0d ready %b exp data %0d ready 0", emptylist_data, meta_ready, id);
            end
         end
         done = (obs_free.size() > 0);
         if (!done) begin
            @(posedge clk); #1;
            rel++;
         end
      end
      done_rel = rel;
      out_almost_full = 4'd0;
      emptylist_ready = 1'b1;
      total++;
      if (!done) begin
         bad++;
         $display("FAIL free_timeout: got no emptylist push exp pkt %0d", id);
      end
      total++;
      if (hold_cnt != er_hold) begin
         bad++;
         $display("FAIL free_hold_cycles: got %0d exp %0d", hold_cnt, er_hold);
      end
      n = (flags == 1 || flits == 0) ? 0 : ((flits > 32) ? 32 : flits);
      exp_v = 4'd1 << ch;
      total++;
      if (obs_rd.size() != n) begin
         bad++;
         $display("FAIL read_count: got %0d exp %0d (pkt %0d)", obs_rd.size(), n, id);
      end
      for (int i = 0; i < n && i < obs_rd.size(); i++) begin
         exp_a = {5'(id), 5'(i)};
         total++;
         if (obs_rd[i].a !== exp_a || obs_rd[i].af[ch] !== 1'b0) begin
            bad++;
            $display("FAIL read_addr[%0d]: got %0h af %b exp %0h af 0", i, obs_rd[i].a, obs_rd[i].af[ch], exp_a);
         end
      end
      total++;
      if (obs_fl.size() != n) begin
         bad++;
         $display("FAIL flit_count: got %0d exp %0d (pkt %0d)", obs_fl.size(), n, id);
      end
      for (int i = 0; i < n && i < obs_fl.size(); i++) begin
         logic [3:0] es, ee;
         logic [5:0] xe;
         exp_a = {5'(id), 5'(i)};
         es = (i == 0) ? exp_v : 4'd0;
         ee = (i == n - 1) ? exp_v : 4'd0;
         xe = (i == n - 1) ? mem_empty(exp_a) : 6'd0;
         total++;
         if (obs_fl[i].v !== exp_v || obs_fl[i].sop !== es || obs_fl[i].eop !== ee ||
             obs_fl[i].e !== xe || obs_fl[i].d !== mem_data(exp_a)) begin
            bad++;
            $display("FAIL flit[%0d]: got v%b s%b e%b emp%0d d%0h exp v%b s%b e%b emp%0d d%0h", i,
                     obs_fl[i].v, obs_fl[i].sop, obs_fl[i].eop, obs_fl[i].e, obs_fl[i].d[31:0],
                     exp_v, es, ee, xe, mem_data(exp_a) & 512'hFFFF_FFFF);
         end
      end
      if (done) begin
         total++;
         if (obs_free[0] !== 5'(id)) begin
            bad++;
            $display("FAIL emptylist_data: got %0d exp %0d", obs_free[0], id);
         end
      end
      if (flags < 5) m_flag[flags] = sat_inc(m_flag[flags]);
      if (flits == 0) m_nop = sat_inc(m_nop);
      if (n > 0) m_chan[ch] = sat_inc(m_chan[ch]);
      check_stats("pkt");
   endtask

   task automatic test_reset();
      model_clear();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      total++;
      if (meta_ready !== 1'b0 || pkt_buffer_read !== 1'b0 || emptylist_valid !== 1'b0 ||
          out_valid !== 4'd0 || out_sop !== 4'd0 || out_eop !== 4'd0) begin
         bad++;
         $display("FAIL reset_outputs: got rdy%b rd%b el%b v%b exp all 0", meta_ready, pkt_buffer_read, emptylist_valid, out_valid);
      end
      check_stats("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk); #1;
      total++;
      if (meta_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_release_ready: got %b exp 1", meta_ready);
      end
   endtask

   task automatic test_directed();
      int r;
      lat_min = 3; lat_max = 3;
      send_pkt(3, 4, 2, 2, 99, 0, 0, 1'b0, r);
      lat_min = 1; lat_max = 4;
      send_pkt(7, 5, 1, 1, 99, 0, 0, 1'b0, r);
      total++;
      if (r > 2) begin
         bad++;
         $display("FAIL drop_free_latency: got %0d exp <=2", r);
      end
      send_pkt(9, 6, 0, 1, 2, 3, 0, 1'b0, r);
      send_pkt(11, 3, 3, 0, 99, 0, 5, 1'b0, r);
      send_pkt(12, 1, 4, 3, 99, 0, 0, 1'b0, r);
      send_pkt(13, 0, 2, 2, 99, 0, 0, 1'b0, r);
      send_pkt(14, 32, 0, 0, 99, 0, 0, 1'b0, r);
      send_pkt(15, 40, 2, 3, 99, 0, 0, 1'b0, r);
      send_pkt(16, 3, 6, 1, 99, 0, 0, 1'b0, r);
   endtask

   task automatic test_random();
      int r;
      for (int k = 0; k < 30; k++)
         send_pkt($urandom_range(0, 31), $urandom_range(0, 40), $urandom_range(0, 7),
                  $urandom_range(0, 3), 99, 0, $urandom_range(0, 2), 1'b1, r);
   endtask

   task automatic test_back_to_back();
      int r;
      for (int k = 0; k < 4; k++) send_pkt(20 + k, 2, 0, k, 99, 0, 0, 1'b0, r);
   endtask

   task automatic test_saturation();
      int r;
      while (m_flag[0] < SMAX - 1) send_pkt(1, 0, 0, 0, 99, 0, 0, 1'b0, r);
      for (int k = 0; k < 3; k++) send_pkt(2, 0, 0, 1, 99, 0, 0, 1'b0, r);
      total++;
      if (stats_flag[SW-1:0] !== 8'hFF) begin
         bad++;
         $display("FAIL forward_saturate: got %0d exp 255", stats_flag[SW-1:0]);
      end
   endtask

   task automatic test_mid_reset();
      int w, r;
      w = 0;
      while (!meta_ready && w < 200) begin
         @(negedge clk); #1;
         w++;
      end
      obs_rd.delete(); obs_fl.delete(); obs_free.delete();
      lat_min = 1; lat_max = 1;
      @(posedge clk); #1;
      meta_valid = 1'b1;
      meta_data.pkt_id = 5'd5; meta_data.flits = 8'd5; meta_data.pkt_flags = 3'd0;
      meta_chan = 2'd1;
      @(posedge clk); #1;
      meta_valid = 1'b0;
      w = 0;
      while (obs_fl.size() < 2 && w < 200) begin
         @(negedge clk); #1;
         w++;
      end
      total++;
      if (obs_fl.size() < 2) begin
         bad++;
         $display("FAIL midreset_progress: got %0d flits exp 2", obs_fl.size());
      end
      rst = 1'b1;
      #1;
      total++;
      if (out_valid !== 4'd0 || out_sop !== 4'd0 || out_eop !== 4'd0 || pkt_buffer_read !== 1'b0 ||
          emptylist_valid !== 1'b0 || meta_ready !== 1'b0) begin
         bad++;
         $display("FAIL midreset_outputs: got v%b rd%b el%b rdy%b exp all 0", out_valid, pkt_buffer_read, emptylist_valid, meta_ready);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
      lat_min = 1; lat_max = 4;
      repeat (6) @(negedge clk);
      #1;
      total++;
      if (obs_free.size() != 0) begin
         bad++;
         $display("FAIL midreset_no_free: got %0d pushes exp 0", obs_free.size());
      end
      check_stats("midreset");
      send_pkt(6, 5, 2, 3, 99, 0, 0, 1'b0, r);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_saturation();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
